// File: rtl/id_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | id_stage : MIPS decode stage - IF/ID register, control decode, ID redirect. |
// | Rev 1.0  : initial release                                                  |
// +-----------------------------------------------------------------------------+
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_instr,
  input  logic        i_stall,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic [4:0]  o_rs_addr,
  output logic [4:0]  o_rt_addr,
  output logic        o_is_branch,
  output logic [31:0] o_branch_offset,
  output logic        o_is_jump,
  output logic [25:0] o_jump_index,
  output logic        o_is_jump_reg,
  output logic [31:0] o_jump_reg_addr,
  output logic        o_reg_write,
  output logic [4:0]  o_wa,
  output logic [2:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_mem_write,
  output logic        o_mem_to_reg,
  output logic        o_link,
  output logic [31:0] o_ext_imm,
  output logic [31:0] o_link_pc
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else if (!i_stall) begin
      r_pc    <= i_if_pc;
      r_instr <= i_if_instr;
    end
  end

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_sext;

  assign w_op    = r_instr[31:26];
  assign w_funct = r_instr[5:0];
  assign w_rt    = r_instr[20:16];
  assign w_rd    = r_instr[15:11];
  assign w_imm   = r_instr[15:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};

  logic        w_beq;
  logic        w_jump;
  logic        w_jreg;
  logic        w_rw;
  logic [4:0]  w_wa;
  logic [2:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_mw;
  logic        w_m2r;
  logic        w_link;
  logic [31:0] w_ext_imm;

  always_comb begin
    w_beq     = 1'b0;
    w_jump    = 1'b0;
    w_jreg    = 1'b0;
    w_rw      = 1'b0;
    w_wa      = 5'd0;
    w_alu_op  = 3'd0;
    w_alu_src = 1'b0;
    w_mw      = 1'b0;
    w_m2r     = 1'b0;
    w_link    = 1'b0;
    w_ext_imm = 32'd0;
    case (w_op)
      c_OP_RTYPE: begin
        case (w_funct)
          c_FN_ADDU: begin w_rw = 1'b1; w_wa = w_rd; w_alu_op = 3'd0; end
          c_FN_SUBU: begin w_rw = 1'b1; w_wa = w_rd; w_alu_op = 3'd1; end
          c_FN_JR:   w_jreg = 1'b1;
          default:   ;
        endcase
      end
      c_OP_ORI: begin
        w_rw = 1'b1; w_wa = w_rt; w_alu_op = 3'd2; w_alu_src = 1'b1;
        w_ext_imm = {16'd0, w_imm};
      end
      c_OP_LW: begin
        w_rw = 1'b1; w_wa = w_rt; w_alu_src = 1'b1; w_m2r = 1'b1;
        w_ext_imm = w_sext;
      end
      c_OP_SW: begin
        w_mw = 1'b1; w_alu_src = 1'b1; w_ext_imm = w_sext;
      end
      c_OP_LUI: begin
        w_rw = 1'b1; w_wa = w_rt; w_alu_op = 3'd3; w_alu_src = 1'b1;
        w_ext_imm = {w_imm, 16'd0};
      end
      c_OP_JAL: begin
        w_rw = 1'b1; w_wa = 5'd31; w_link = 1'b1; w_jump = 1'b1;
      end
      c_OP_J:   w_jump = 1'b1;
      c_OP_BEQ: w_beq  = 1'b1;
      default:  ;
    endcase
  end

  // A stalled cycle sends a bubble to ID/EX and must not redirect fetch.
  assign o_is_branch     = w_beq && (i_rs_val == i_rt_val) && !i_stall;
  assign o_is_jump       = w_jump && !i_stall;
  assign o_is_jump_reg   = w_jreg && !i_stall;
  assign o_reg_write     = w_rw && (w_wa != 5'd0) && !i_stall;
  assign o_mem_write     = w_mw && !i_stall;
  assign o_mem_to_reg    = w_m2r && !i_stall;
  assign o_link          = w_link && !i_stall;

  assign o_wa            = w_wa;
  assign o_alu_op        = w_alu_op;
  assign o_alu_src       = w_alu_src;
  assign o_ext_imm       = w_ext_imm;
  assign o_branch_offset = w_sext;
  assign o_jump_index    = r_instr[25:0];
  assign o_jump_reg_addr = i_rs_val;
  assign o_rs_addr       = r_instr[25:21];
  assign o_rt_addr       = w_rt;
  assign o_id_pc         = r_pc;
  assign o_id_instr      = r_instr;
  assign o_link_pc       = r_pc + 32'd8;

endmodule
`default_nettype wire
